// File: rtl/wb_copy_master.sv
// Wishbone block-copy initiator: moves 32-bit words from a source to a
// destination region using alternating single-beat classic read/write cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; also issues the deferred done for len=0
// RD     | read cycle on the bus, waiting for ack
// RD_GAP | one idle bus cycle after the read ack
// WR     | write cycle on the bus, waiting for ack
// WR_GAP | one idle bus cycle after the write ack, before the next read
module wb_copy_master #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [31:0]      src_adr,
  input  logic [31:0]      dst_adr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  output logic             wbm_we_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RD_GAP = 3'd2,
    WR     = 3'd3,
    WR_GAP = 3'd4
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [29:0]       src_q, src_d;
  logic [29:0]       dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              zero_q, zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic              cyc_q, cyc_d;

  // Byte-offset bits of the command addresses are intentionally discarded.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{src_adr[1:0], dst_adr[1:0]};

  // Next-state and next-output computation for the copy sequencer.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    to_d    = to_q;
    zero_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;

    case (state_q)
      IDLE: begin
        if (zero_q) begin
          // Zero-length command: finish one cycle after acceptance.
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (start) begin
          busy_d = 1'b1;
          err_d  = 1'b0;
          src_d  = src_adr[31:2];
          dst_d  = dst_adr[31:2];
          cnt_d  = len;
          if (len == '0) begin
            zero_d = 1'b1;
          end else begin
            state_d = RD;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            sel_d   = 4'hF;
            adr_d   = {src_adr[31:2], 2'b00};
            to_d    = '0;
          end
        end
      end

      RD: begin
        if (wbm_ack_i) begin
          buf_d   = wbm_dat_i;
          cyc_d   = 1'b0;
          sel_d   = 4'h0;
          state_d = RD_GAP;
        end else if (TO_EN && (to_q == TO_LAST)) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'h0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      RD_GAP: begin
        state_d = WR;
        cyc_d   = 1'b1;
        we_d    = 1'b1;
        sel_d   = 4'hF;
        adr_d   = {dst_q, 2'b00};
        dat_d   = buf_q;
        to_d    = '0;
      end

      WR: begin
        if (wbm_ack_i) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          sel_d = 4'h0;
          src_d = src_q + 30'd1;
          dst_d = dst_q + 30'd1;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = WR_GAP;
          end
        end else if (TO_EN && (to_q == TO_LAST)) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'h0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      WR_GAP: begin
        state_d = RD;
        cyc_d   = 1'b1;
        we_d    = 1'b0;
        sel_d   = 4'hF;
        adr_d   = {src_q, 2'b00};
        to_d    = '0;
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
        sel_d   = 4'h0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears the bus immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      to_q    <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      to_q    <= to_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: a Wishbone slave with programmable ack latency
// and a word-level copy model that predicts bus traffic, done timing and
// final memory contents.
module tb_wb_copy_master;

  localparam int LEN_W = 16;
  localparam int TO    = 8;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src_adr = '0;
  logic [31:0]      dst_adr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err;
  logic [31:0]      wbm_adr_o, wbm_dat_o;
  logic [3:0]       wbm_sel_o;
  logic             wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic             ack = 1'b0;
  logic [31:0]      rdata = '0;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  txn_t        log_q[$];
  txn_t        exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int lat_cfg = 1;
  int ack_mode = 0;   // 0 normal, 1 never ack, 2 ack reads only
  int age = 0;

  wb_copy_master #(.LEN_W(LEN_W), .TIMEOUT(TO), .TO_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .start    (start),
    .src_adr  (src_adr),
    .dst_adr  (dst_adr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_we_o (wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_ack_i(ack),
    .wbm_dat_i(rdata)
  );

  always #5 clk = ~clk;

  // Slave: ack in the lat_cfg-th cycle of stb, logging each completed beat.
  always @(negedge clk) begin
    txn_t t;
    if (!rst_n || !(wbm_cyc_o && wbm_stb_o)) begin
      age = 0;
      ack = 1'b0;
    end else begin
      age++;
      if (age == lat_cfg && (ack_mode == 0 || (ack_mode == 2 && !wbm_we_o))) begin
        ack   = 1'b1;
        t.adr = wbm_adr_o;
        t.we  = wbm_we_o;
        t.sel = wbm_sel_o;
        if (wbm_we_o) begin
          t.dat = wbm_dat_o;
          mem[wbm_adr_o[11:2]] = wbm_dat_o;
        end else begin
          t.dat = '0;
          rdata = mem[wbm_adr_o[11:2]];
        end
        log_q.push_back(t);
      end else begin
        ack = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx]     = v;
    ref_mem[idx] = v;
  endtask

  // Issue one command and check timing, traffic and status against the model.
  task automatic run_cmd(input string tag, input logic [31:0] s, input logic [31:0] d,
                         input int n, input int lat, input bit pulse_mid);
    txn_t e;
    logic [31:0] ra, wa, v;
    int exp_done, k, nchk;
    bit busy_ok, stb_ok, cyc_seen;
    lat_cfg  = lat;
    ack_mode = 0;
    log_q.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      ra = (s & 32'hFFFF_FFFC) + 32'(4 * i);
      wa = (d & 32'hFFFF_FFFC) + 32'(4 * i);
      v  = ref_mem[ra[11:2]];
      e.adr = ra; e.we = 1'b0; e.dat = '0; e.sel = 4'hF;
      exp_q.push_back(e);
      e.adr = wa; e.we = 1'b1; e.dat = v;  e.sel = 4'hF;
      exp_q.push_back(e);
      ref_mem[wa[11:2]] = v;
    end
    exp_done = (n == 0) ? 1 : 2 * (lat + 1) * n - 1;

    @(posedge clk); #1;
    start = 1'b1; src_adr = s; dst_adr = d; len = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0; src_adr = $urandom; dst_adr = $urandom; len = LEN_W'($urandom);

    k = 0; busy_ok = 1'b1; stb_ok = 1'b1; cyc_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (k == 0) begin
        chk({tag, "_err_clr"}, err, 0);
        chk({tag, "_busy0"}, busy, 1);
      end
      if (wbm_cyc_o) cyc_seen = 1'b1;
      if (wbm_stb_o !== wbm_cyc_o) stb_ok = 1'b0;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (pulse_mid) begin
        start = (k == 2);
        if (k == 2) begin
          src_adr = $urandom; dst_adr = $urandom; len = LEN_W'($urandom_range(1, 50));
        end
      end
      if (k >= 500) break;
      @(posedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, k, exp_done);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy_held"}, busy_ok, 1);
    chk({tag, "_stb_eq_cyc"}, stb_ok, 1);
    if (n == 0) chk({tag, "_no_cyc"}, cyc_seen, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_ntxn"}, log_q.size(), exp_q.size());
    nchk = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < nchk; i++) begin
      chk({tag, "_adr"}, log_q[i].adr, exp_q[i].adr);
      chk({tag, "_we"},  log_q[i].we,  exp_q[i].we);
      chk({tag, "_dat"}, log_q[i].dat, exp_q[i].dat);
      chk({tag, "_sel"}, log_q[i].sel, exp_q[i].sel);
    end
  endtask

  int k, stbcnt, nbad;
  bit got;

  initial begin
    for (int i = 0; i < 1024; i++) set_word(i, $urandom);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_we", wbm_we_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_sel", wbm_sel_o, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single word, latency 1
    set_word(0, 32'hDEADBEEF);
    run_cmd("single", 32'h0, 32'h100, 1, 1, 1'b0);

    // Four-word block, latency 2
    set_word(0, 32'h11111111); set_word(1, 32'h22222222);
    set_word(2, 32'h33333333); set_word(3, 32'h44444444);
    run_cmd("block", 32'h0, 32'h200, 4, 2, 1'b0);

    // Zero length
    run_cmd("len0", 32'h40, 32'h80, 0, 1, 1'b0);

    // Source address wraps past 2^32
    run_cmd("wrap", 32'hFFFF_FFFC, 32'h300, 2, 1, 1'b0);

    // Start pulsed while busy is ignored; unaligned addresses are truncated
    run_cmd("busy_start", 32'h0000_0403, 32'h0000_0602, 3, 1, 1'b1);

    // Random commands
    for (int r = 0; r < 8; r++)
      run_cmd("rand", $urandom, $urandom, $urandom_range(1, 5), $urandom_range(1, 3), 1'b0);

    // Timeout: slave never acks
    ack_mode = 1;
    log_q.delete();
    @(posedge clk); #1;
    start = 1'b1; src_adr = 32'h10; dst_adr = 32'h700; len = 3;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; stbcnt = 0; got = 1'b0;
    while (k < 60) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (wbm_stb_o) stbcnt++;
      @(posedge clk);
      k++;
    end
    chk("to_done_seen", got, 1);
    chk("to_stb_cycles", stbcnt, TO);
    chk("to_done_cycle", k, TO);
    chk("to_err", err, 1);
    chk("to_cyc", wbm_cyc_o, 0);
    chk("to_busy", busy, 0);
    @(negedge clk);
    chk("to_done_pulse", done, 0);
    chk("to_err_hold", err, 1);
    chk("to_no_txn", log_q.size(), 0);

    // Next command clears err
    run_cmd("after_to", 32'h20, 32'h800, 2, 1, 1'b0);

    // Reset while a write is holding stb
    ack_mode = 2; lat_cfg = 1;
    @(posedge clk); #1;
    start = 1'b1; src_adr = 32'h40; dst_adr = 32'h500; len = 2;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (wbm_we_o && wbm_stb_o) break;
      k++;
    end
    chk("rst_mid_reach_wr", (k < 50), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", wbm_cyc_o, 0);
    chk("rst_mid_stb", wbm_stb_o, 0);
    chk("rst_mid_we", wbm_we_o, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_mode = 0;
    run_cmd("after_rst", 32'h30, 32'h900, 3, 2, 1'b0);

    // Whole memory against the model
    nbad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk("mem_final", nbad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
